// File: rtl/bus_pkg.sv
// Shared definitions for the IF/MEM bus arbiter: FSM state encoding,
// bus read/write control codes and the bus width.
package bus_pkg;

    localparam int BUS_W  = 64;
    localparam int INSN_W = 32;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY_IF = 2'd1,
        ST_BUSY_DM = 2'd2
    } arb_state_t;

    // Control code 0 means "no access" on both the read and write sides.
    localparam logic [2:0] CTRL_NONE = 3'd0;

    // Read control codes (signed variants sign-extend, *U variants zero-extend).
    localparam logic [2:0] RD_B  = 3'd1;
    localparam logic [2:0] RD_H  = 3'd2;
    localparam logic [2:0] RD_W  = 3'd3;
    localparam logic [2:0] RD_D  = 3'd4;
    localparam logic [2:0] RD_WU = 3'd5;   // 32-bit zero-extended: instruction fetch
    localparam logic [2:0] RD_BU = 3'd6;
    localparam logic [2:0] RD_HU = 3'd7;

    // Write control codes.
    localparam logic [2:0] WR_B = 3'd1;
    localparam logic [2:0] WR_H = 3'd2;
    localparam logic [2:0] WR_W = 3'd3;
    localparam logic [2:0] WR_D = 3'd4;

    // True while an access owns the bus.
    function automatic logic is_busy(input arb_state_t s);
        return (s == ST_BUSY_IF) || (s == ST_BUSY_DM);
    endfunction

endpackage

// File: rtl/arb_timeout_counter.sv
// Counts BUSY cycles without bus_ready and flags the cycle in which the
// access must be aborted. TIMEOUT_CYCLES = 0 disables the abort entirely.
module arb_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic expire
);

    localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [W-1:0] LAST = (TIMEOUT_CYCLES > 0) ? W'(TIMEOUT_CYCLES - 1) : '0;

    logic [W-1:0] count;

    // Waiting-cycle counter; saturates at LAST, cleared whenever the bus is idle.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (count_en && (count != LAST)) begin
            count <= count + 1'b1;
        end
    end

    // Abort in the cycle where the count has reached LAST and the bus is still not ready.
    assign expire = (TIMEOUT_CYCLES > 0) && count_en && (count == LAST);

endmodule

// File: rtl/bus_arbiter.sv
// Arbiter sharing one system bus between the IF fetch port and the MEM data
// port. Data normally wins; a fetch that has waited through MAX_DM_STREAK
// data grants is forced through. Each access takes a grant cycle in IDLE
// plus at least one BUSY cycle, and is aborted with bus_err after
// TIMEOUT_CYCLES waiting cycles.
// Optional build macro ARB_PERF_CNT_EN adds grant/conflict performance counters.
//
// Handshake: a requester raises x_req and holds it (with stable address,
// control and data) until x_ready pulses for exactly one cycle; x_rdata is
// valid only in that cycle. The bus side sees ctrl/addr/din held stable for
// the whole BUSY period and completes the access in the first cycle
// bus_ready is high.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int         MAX_DM_STREAK  = 4,
    parameter int         TIMEOUT_CYCLES = 16,
    parameter logic [2:0] IF_RD_CTRL     = 3'd5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [BUS_W-1:0]  if_addr,
    output logic [INSN_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              dm_req,
    input  logic [2:0]        dm_rd_ctrl,
    input  logic [2:0]        dm_wr_ctrl,
    input  logic [BUS_W-1:0]  dm_addr,
    input  logic [BUS_W-1:0]  dm_wdata,
    output logic [BUS_W-1:0]  dm_rdata,
    output logic              dm_ready,
    output logic [2:0]        bus_rd_ctrl,
    output logic [2:0]        bus_wr_ctrl,
    output logic [BUS_W-1:0]  bus_addr,
    output logic [BUS_W-1:0]  bus_din,
    input  logic [BUS_W-1:0]  bus_dout,
    input  logic              bus_ready,
    output logic              bus_err,
    output logic              stall_if,
    output logic              stall_mem,
`ifdef ARB_PERF_CNT_EN
    output logic [31:0]       perf_if_grants,
    output logic [31:0]       perf_dm_grants,
    output logic [31:0]       perf_conflict_cycles,
`endif
    output arb_state_t        dbg_state
);

    localparam int SW = (MAX_DM_STREAK > 0) ? $clog2(MAX_DM_STREAK + 1) : 1;
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DM_STREAK);

    arb_state_t       state, state_next;
    logic [SW-1:0]    streak;
    logic [BUS_W-1:0] hold_addr, hold_wdata;
    logic [2:0]       hold_rd, hold_wr;
    logic             grant_if, grant_dm;
    logic             starve;
    logic             expire;

    // Fetch has waited through enough back-to-back data grants.
    assign starve = (MAX_DM_STREAK > 0) && (streak >= STREAK_MAX);

    arb_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .clear    (~is_busy(state)),
        .count_en (is_busy(state) & ~bus_ready),
        .expire   (expire)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, grants and all combinational outputs.
    always_comb begin
        state_next  = state;
        grant_if    = 1'b0;
        grant_dm    = 1'b0;
        bus_rd_ctrl = CTRL_NONE;
        bus_wr_ctrl = CTRL_NONE;
        bus_addr    = '0;
        bus_din     = '0;
        if_ready    = 1'b0;
        if_rdata    = '0;
        dm_ready    = 1'b0;
        dm_rdata    = '0;
        bus_err     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (if_req && (!dm_req || starve)) begin
                    grant_if   = 1'b1;
                    state_next = ST_BUSY_IF;
                end else if (dm_req) begin
                    grant_dm   = 1'b1;
                    state_next = ST_BUSY_DM;
                end
            end
            ST_BUSY_IF: begin
                bus_rd_ctrl = hold_rd;
                bus_wr_ctrl = hold_wr;
                bus_addr    = hold_addr;
                bus_din     = hold_wdata;
                if (bus_ready) begin
                    if_ready   = 1'b1;
                    if_rdata   = bus_dout[INSN_W-1:0];
                    state_next = ST_IDLE;
                end else if (expire) begin
                    if_ready   = 1'b1;
                    bus_err    = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_BUSY_DM: begin
                bus_rd_ctrl = hold_rd;
                bus_wr_ctrl = hold_wr;
                bus_addr    = hold_addr;
                bus_din     = hold_wdata;
                if (bus_ready) begin
                    dm_ready   = 1'b1;
                    dm_rdata   = bus_dout;
                    state_next = ST_IDLE;
                end else if (expire) begin
                    dm_ready   = 1'b1;
                    bus_err    = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        // A reset cycle never completes an access, even if bus_ready is high.
        if (rst) begin
            if_ready = 1'b0;
            if_rdata = '0;
            dm_ready = 1'b0;
            dm_rdata = '0;
            bus_err  = 1'b0;
        end
    end

    // Holding registers: capture the winner so the bus is insulated from requester changes.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_addr  <= '0;
            hold_wdata <= '0;
            hold_rd    <= CTRL_NONE;
            hold_wr    <= CTRL_NONE;
        end else if (grant_if) begin
            hold_addr  <= if_addr;
            hold_wdata <= '0;
            hold_rd    <= IF_RD_CTRL;
            hold_wr    <= CTRL_NONE;
        end else if (grant_dm) begin
            hold_addr  <= dm_addr;
            hold_wdata <= dm_wdata;
            hold_rd    <= dm_rd_ctrl;
            hold_wr    <= dm_wr_ctrl;
        end
    end

    // Streak of data grants taken while a fetch was waiting.
    always_ff @(posedge clk) begin
        if (rst || grant_if) begin
            streak <= '0;
        end else if (grant_dm && if_req && (streak < STREAK_MAX)) begin
            streak <= streak + 1'b1;
        end
    end

    assign stall_if  = if_req & ~if_ready;
    assign stall_mem = dm_req & ~dm_ready;
    assign dbg_state = state;

`ifdef ARB_PERF_CNT_EN
    // Free-running performance counters, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_if_grants       <= '0;
            perf_dm_grants       <= '0;
            perf_conflict_cycles <= '0;
        end else begin
            if (grant_if) perf_if_grants <= perf_if_grants + 32'd1;
            if (grant_dm) perf_dm_grants <= perf_dm_grants + 32'd1;
            if (if_req && dm_req) perf_conflict_cycles <= perf_conflict_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios with literal
// expectations plus a randomized phase, all checked every cycle against a
// transaction-level model of the arbitration rules.
module tb_bus_arbiter;
    import bus_pkg::*;

    localparam int         MAX_STREAK = 4;
    localparam int         TMO        = 16;
    localparam logic [2:0] IF_CTRL    = 3'd5;

    logic        clk, rst;
    logic        if_req, if_ready;
    logic [63:0] if_addr;
    logic [31:0] if_rdata;
    logic        dm_req, dm_ready;
    logic [2:0]  dm_rd_ctrl, dm_wr_ctrl;
    logic [63:0] dm_addr, dm_wdata, dm_rdata;
    logic [2:0]  bus_rd_ctrl, bus_wr_ctrl;
    logic [63:0] bus_addr, bus_din, bus_dout;
    logic        bus_ready, bus_err, stall_if, stall_mem;
    arb_state_t  dbg_state;
`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_if_grants, perf_dm_grants, perf_conflict_cycles;
`endif

    bus_arbiter #(
        .MAX_DM_STREAK (MAX_STREAK),
        .TIMEOUT_CYCLES(TMO),
        .IF_RD_CTRL    (IF_CTRL)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .dm_req(dm_req), .dm_rd_ctrl(dm_rd_ctrl), .dm_wr_ctrl(dm_wr_ctrl),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .bus_rd_ctrl(bus_rd_ctrl), .bus_wr_ctrl(bus_wr_ctrl), .bus_addr(bus_addr),
        .bus_din(bus_din), .bus_dout(bus_dout), .bus_ready(bus_ready), .bus_err(bus_err),
        .stall_if(stall_if), .stall_mem(stall_mem),
`ifdef ARB_PERF_CNT_EN
        .perf_if_grants(perf_if_grants), .perf_dm_grants(perf_dm_grants),
        .perf_conflict_cycles(perf_conflict_cycles),
`endif
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // owner: 0 = bus free, 1 = fetch access in flight, 2 = data access in flight.
    bit          m_on = 1'b0;
    int          m_owner = 0, m_wait = 0, m_streak = 0;
    logic [63:0] m_addr = '0, m_wdata = '0;
    logic [2:0]  m_rd = '0, m_wr = '0;
    logic [31:0] m_pif = '0, m_pdm = '0, m_pconf = '0;
    int          n_owner, n_wait, n_streak;
    logic [63:0] n_addr, n_wdata;
    logic [2:0]  n_rd, n_wr;
    logic [31:0] n_pif, n_pdm, n_pconf;

    always @(negedge clk) begin : model_cmp
        logic        e_ifr, e_dmr, e_err, done, tmo;
        logic [31:0] e_ifd;
        logic [63:0] e_dmd, e_addr, e_din;
        logic [2:0]  e_rd, e_wr;
        e_ifr = 0; e_dmr = 0; e_err = 0; e_ifd = '0; e_dmd = '0;
        e_addr = '0; e_din = '0; e_rd = '0; e_wr = '0; done = 0; tmo = 0;
        if (m_owner != 0) begin
            e_addr = m_addr; e_din = m_wdata; e_rd = m_rd; e_wr = m_wr;
            tmo  = (TMO > 0) && !bus_ready && (m_wait == TMO - 1);
            done = bus_ready || tmo;
            if (!rst && done) begin
                e_err = tmo;
                if (m_owner == 1) begin
                    e_ifr = 1'b1;
                    e_ifd = bus_ready ? bus_dout[31:0] : 32'd0;
                end else begin
                    e_dmr = 1'b1;
                    e_dmd = bus_ready ? bus_dout : 64'd0;
                end
            end
        end
        if (m_on) begin
            chk("model_bus_rd_ctrl", 64'(bus_rd_ctrl), 64'(e_rd));
            chk("model_bus_wr_ctrl", 64'(bus_wr_ctrl), 64'(e_wr));
            chk("model_bus_addr", bus_addr, e_addr);
            chk("model_bus_din", bus_din, e_din);
            chk("model_if_ready", 64'(if_ready), 64'(e_ifr));
            chk("model_if_rdata", 64'(if_rdata), 64'(e_ifd));
            chk("model_dm_ready", 64'(dm_ready), 64'(e_dmr));
            chk("model_dm_rdata", dm_rdata, e_dmd);
            chk("model_bus_err", 64'(bus_err), 64'(e_err));
            chk("model_stall_if", 64'(stall_if), 64'(if_req & ~e_ifr));
            chk("model_stall_mem", 64'(stall_mem), 64'(dm_req & ~e_dmr));
`ifdef ARB_PERF_CNT_EN
            chk("model_perf_if", 64'(perf_if_grants), 64'(m_pif));
            chk("model_perf_dm", 64'(perf_dm_grants), 64'(m_pdm));
            chk("model_perf_conf", 64'(perf_conflict_cycles), 64'(m_pconf));
`endif
        end
        // Next model state, committed at the following rising edge.
        n_owner = m_owner; n_wait = m_wait; n_streak = m_streak;
        n_addr = m_addr; n_wdata = m_wdata; n_rd = m_rd; n_wr = m_wr;
        n_pif = m_pif; n_pdm = m_pdm; n_pconf = m_pconf;
        if (rst) begin
            n_owner = 0; n_wait = 0; n_streak = 0;
            n_addr = '0; n_wdata = '0; n_rd = '0; n_wr = '0;
            n_pif = '0; n_pdm = '0; n_pconf = '0;
        end else begin
            if (if_req && dm_req) n_pconf = m_pconf + 32'd1;
            if (m_owner == 0) begin
                if (if_req && (!dm_req || (MAX_STREAK > 0 && m_streak >= MAX_STREAK))) begin
                    n_owner = 1; n_addr = if_addr; n_rd = IF_CTRL; n_wr = '0; n_wdata = '0;
                    n_streak = 0; n_pif = m_pif + 32'd1; n_wait = 0;
                end else if (dm_req) begin
                    n_owner = 2; n_addr = dm_addr; n_rd = dm_rd_ctrl; n_wr = dm_wr_ctrl;
                    n_wdata = dm_wdata; n_pdm = m_pdm + 32'd1; n_wait = 0;
                    if (if_req && m_streak < MAX_STREAK) n_streak = m_streak + 1;
                end
            end else if (done) begin
                n_owner = 0;
            end else begin
                n_wait = m_wait + 1;
            end
        end
    end

    always @(posedge clk) begin
        m_owner <= n_owner; m_wait <= n_wait; m_streak <= n_streak;
        m_addr <= n_addr; m_wdata <= n_wdata; m_rd <= n_rd; m_wr <= n_wr;
        m_pif <= n_pif; m_pdm <= n_pdm; m_pconf <= n_pconf;
        if (rst) m_on <= 1'b1;
    end

    // ---------------- driver / directed + random stimulus ----------------
    int seq[$];
    int exp_seq[6] = '{2, 2, 2, 2, 1, 2};
    int busy_cycles;
    bit got, r_ifr, r_dmr;

    initial begin
        rst = 1; if_req = 0; if_addr = '0; dm_req = 0; dm_rd_ctrl = '0; dm_wr_ctrl = '0;
        dm_addr = '0; dm_wdata = '0; bus_dout = '0; bus_ready = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("reset_bus_addr", bus_addr, 64'd0);
        chk("reset_bus_rd_ctrl", 64'(bus_rd_ctrl), 64'd0);
        chk("reset_if_ready", 64'(if_ready), 64'd0);
        chk("reset_dm_ready", 64'(dm_ready), 64'd0);
        chk("reset_bus_err", 64'(bus_err), 64'd0);

        // Fetch only: grant cycle then completion cycle.
        @(posedge clk); #1;
        if_req = 1; if_addr = 64'h1000; bus_ready = 1; bus_dout = 64'h13;
        @(negedge clk);
        chk("fetch_grant_bus_addr", bus_addr, 64'd0);
        chk("fetch_grant_no_ready", 64'(if_ready), 64'd0);
        chk("fetch_grant_stall", 64'(stall_if), 64'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("fetch_bus_addr", bus_addr, 64'h1000);
        chk("fetch_rd_ctrl", 64'(bus_rd_ctrl), 64'd5);
        chk("fetch_ready", 64'(if_ready), 64'd1);
        chk("fetch_rdata", 64'(if_rdata), 64'h13);
        chk("fetch_stall_released", 64'(stall_if), 64'd0);
        @(posedge clk); #1;
        if_req = 0;

        // Both requesting: data store first, fetch after the next IDLE.
        if_req = 1; if_addr = 64'h1004;
        dm_req = 1; dm_rd_ctrl = 3'd0; dm_wr_ctrl = 3'd4; dm_addr = 64'h2000; dm_wdata = 64'hAB;
        @(negedge clk);
        chk("both_idle_stall_if", 64'(stall_if), 64'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("both_dm_wr_ctrl", 64'(bus_wr_ctrl), 64'd4);
        chk("both_dm_din", bus_din, 64'hAB);
        chk("both_dm_addr", bus_addr, 64'h2000);
        chk("both_dm_ready", 64'(dm_ready), 64'd1);
        chk("both_if_waiting", 64'(if_ready), 64'd0);
        chk("both_stall_if_busy", 64'(stall_if), 64'd1);
        @(posedge clk); #1;
        dm_req = 0;
        @(negedge clk);
        chk("both_if_grant_stall", 64'(stall_if), 64'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("both_if_ready", 64'(if_ready), 64'd1);
        chk("both_if_addr", bus_addr, 64'h1004);
        @(posedge clk); #1;
        if_req = 0;

        // Starvation: both always requesting, expect DM,DM,DM,DM,IF,DM.
        if_req = 1; if_addr = 64'h3000;
        dm_req = 1; dm_rd_ctrl = 3'd4; dm_wr_ctrl = 3'd0; dm_addr = 64'h4000; bus_ready = 1;
        for (int c = 0; c < 40 && seq.size() < 6; c++) begin
            @(negedge clk);
            if (dm_ready) seq.push_back(2);
            if (if_ready) seq.push_back(1);
            @(posedge clk); #1;
        end
        if_req = 0; dm_req = 0;
        chk("starve_count", 64'(seq.size()), 64'd6);
        for (int i = 0; i < 6; i++) begin
            chk("starve_order", 64'((i < seq.size()) ? seq[i] : 0), 64'(exp_seq[i]));
        end

        // Timeout: bus never ready, abort on the 16th BUSY cycle.
        bus_ready = 0; bus_dout = 64'hDEAD_BEEF_0123_4567;
        dm_req = 1; dm_rd_ctrl = 3'd4; dm_wr_ctrl = 3'd0; dm_addr = 64'h5000;
        busy_cycles = 0; got = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus_rd_ctrl != 3'd0) busy_cycles++;
            if (dm_ready) begin
                got = 1;
                chk("tmo_bus_err", 64'(bus_err), 64'd1);
                chk("tmo_rdata_zero", dm_rdata, 64'd0);
            end
            @(posedge clk); #1;
            if (got) break;
        end
        dm_req = 0;
        chk("tmo_seen", 64'(got), 64'd1);
        chk("tmo_busy_cycles", 64'(busy_cycles), 64'd16);
        @(negedge clk);
        chk("tmo_idle_rd_ctrl", 64'(bus_rd_ctrl), 64'd0);
        chk("tmo_idle_err", 64'(bus_err), 64'd0);

        // Reset in the middle of a data access.
        @(posedge clk); #1;
        dm_req = 1; dm_addr = 64'h6000; dm_rd_ctrl = 3'd4;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        chk("midrst_busy_addr", bus_addr, 64'h6000);
        @(posedge clk); #1;
        rst = 1;
        @(negedge clk);
        chk("midrst_no_ready", 64'(dm_ready), 64'd0);
        @(posedge clk); #1;
        rst = 0; dm_req = 0;
        @(negedge clk);
        chk("midrst_rd_ctrl", 64'(bus_rd_ctrl), 64'd0);
        chk("midrst_addr", bus_addr, 64'd0);
        chk("midrst_dm_ready", 64'(dm_ready), 64'd0);
        @(posedge clk); #1;
        if_req = 1; if_addr = 64'h7000; bus_ready = 1; bus_dout = 64'h0000_0000_1234_5678;
        got = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (if_ready) begin
                got = 1;
                chk("midrst_fetch_rdata", 64'(if_rdata), 64'h1234_5678);
                chk("midrst_fetch_addr", bus_addr, 64'h7000);
            end
            @(posedge clk); #1;
            if (got) break;
        end
        if_req = 0;
        chk("midrst_fetch_served", 64'(got), 64'd1);

        // Randomized traffic; requesters follow the hold-until-ready protocol.
        r_ifr = 0; r_dmr = 0;
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            r_ifr = if_ready; r_dmr = dm_ready;
            @(posedge clk); #1;
            rst = (i == 600);
            if (if_req && r_ifr) if_req = 0;
            if (dm_req && r_dmr) dm_req = 0;
            if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req = 1; if_addr = {$urandom(), $urandom()} & ~64'h3;
            end
            if (!dm_req && $urandom_range(0, 2) == 0) begin
                dm_req = 1; dm_addr = {$urandom(), $urandom()};
                dm_wdata = {$urandom(), $urandom()};
                case ($urandom_range(0, 2))
                    0: begin dm_rd_ctrl = 3'($urandom_range(1, 7)); dm_wr_ctrl = 3'd0; end
                    1: begin dm_rd_ctrl = 3'd0; dm_wr_ctrl = 3'($urandom_range(1, 4)); end
                    default: begin dm_rd_ctrl = 3'd0; dm_wr_ctrl = 3'd0; end
                endcase
            end
            bus_ready = (i >= 400 && i < 440) ? 1'b0 : ($urandom_range(0, 2) != 0);
            bus_dout  = {$urandom(), $urandom()};
        end
        if_req = 0; dm_req = 0; rst = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Shares the single system bus between the IF-stage instruction fetch port and the MEM-stage data port.
- Replaces the plain "data access wins" address mux with a registered grant FSM, starvation protection and bus-ready handshake.
- Adds timeout/error reporting.
- Generates stall_if / stall_mem for the hazard unit.

Parameters:
- MAX_DM_STREAK, 4: consecutive data grants allowed while a fetch waits before fetch is forced to win; 0 = pure data priority.
- TIMEOUT_CYCLES, 16: BUSY cycles without bus_ready before abort; 0 = timeout disabled.
- IF_RD_CTRL, 3'd5: bus_rd_ctrl code driven for fetch (32-bit, zero-extend).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request, held until if_ready
- if_addr  in  64  fetch address, stable while if_req
- if_rdata  out  32  fetched instruction, valid with if_ready
- if_ready  out  1  fetch completion pulse
- dm_req  in  1  data request, held until dm_ready
- dm_rd_ctrl  in  3  data read control
- dm_wr_ctrl  in  3  data write control
- dm_addr  in  64  data address
- dm_wdata  in  64  store data
- dm_rdata  out  64  load data, valid with dm_ready
- dm_ready  out  1  data completion pulse
- bus_rd_ctrl  out  3  bus read control
- bus_wr_ctrl  out  3  bus write control
- bus_addr  out  64  bus address
- bus_din  out  64  bus write data
- bus_dout  in  64  bus read data
- bus_ready  in  1  bus completes access this cycle
- bus_err  out  1  one-cycle pulse on timeout abort
- stall_if  out  1  if_req & ~if_ready
- stall_mem  out  1  dm_req & ~dm_ready

Behaviour:
- Reset (rst=1 at edge):
  - state=IDLE; streak=0; timer=0; holding registers=0.
  - All bus_* outputs, *_ready, *_rdata and bus_err are 0.
- States: IDLE, BUSY_IF, BUSY_DM.
- IDLE:
  - No requests: stay IDLE.
  - Arbitration: dm_req wins, unless if_req=1 and streak>=MAX_DM_STREAK (with MAX_DM_STREAK>0), in which case fetch wins.
  - Winner's addr/ctrl/wdata are captured into holding registers; next state BUSY_IF or BUSY_DM.
- Streak counter:
  - +1 on a data grant while if_req=1, saturating at MAX_DM_STREAK.
  - Cleared on any fetch grant.
  - Unchanged on a data grant with if_req=0.
- BUSY_x, bus outputs:
  - Driven from holding registers; requester inputs are not re-sampled.
  - Fetch: bus_rd_ctrl=IF_RD_CTRL, bus_wr_ctrl=0, bus_din=0.
- BUSY_x, completion:
  - Completes in the first cycle with bus_ready=1.
  - That cycle (combinational): x_ready=1; rdata=bus_dout (if_rdata=bus_dout[31:0]).
  - Next state IDLE.
- Latency: minimum 2 cycles per access (grant cycle + completion cycle); max throughput 1 access / 2 cycles.
- No ready is ever issued in IDLE.
- Timeout:
  - timer counts BUSY cycles with bus_ready=0.
  - When timer reaches TIMEOUT_CYCLES-1 and bus_ready=0: x_ready=1, x_rdata=0, bus_err=1 for that cycle; next state IDLE.
  - bus_ready=1 in the same cycle takes precedence (normal completion, no error).
- Outside BUSY_x, x_ready=0 and x_rdata=0.
- IDLE bus outputs: ctrl=0, addr=0, din=0, so no spurious access.
- Simultaneous if_req and dm_req, streak below limit: data wins; fetch stalls (stall_if=1) until a later IDLE grant.
- Requester drops req while BUSY: the transaction still completes and the ready pulse is still issued; the requester must ignore it.
- rst asserted mid-BUSY: IDLE next edge; no ready pulse; bus ctrl=0 from that edge.
- dm_req with both ctrl fields 0 is still granted and completes on bus_ready (no side effect on the bus).

Optional Feature:
- Macro ARB_PERF_CNT_EN.
- Defined: adds output ports perf_if_grants, perf_dm_grants, perf_conflict_cycles (32 bits each).
  - perf_if_grants / perf_dm_grants: +1 per grant of that port.
  - perf_conflict_cycles: +1 per cycle with if_req & dm_req.
  - All wrap at 2^32, reset to 0.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package bus_pkg: state encoding (IDLE/BUSY_IF/BUSY_DM), rd/wr ctrl code constants including the fetch word code, bus width constant 64.
- One natural sub-module: arb_timeout_counter (load/clear/expire, width from TIMEOUT_CYCLES).

Test Plan:
- Fetch only: if_req=1, if_addr=0x1000, bus_ready high in first BUSY cycle, bus_dout=0x00000013 → bus_addr=0x1000 and rd_ctrl=5 in cycle 2; if_ready=1 with if_rdata=0x13 in the same cycle.
- Both requesting: if_req=1, dm_req=1 (store, addr=0x2000, wdata=0xAB) → data granted first (bus_wr_ctrl=dm_wr_ctrl, bus_din=0xAB); fetch granted after IDLE; stall_if=1 throughout the wait.
- Starvation: dm_req held high with a new access after each ready, if_req constantly 1, MAX_DM_STREAK=4 → grants DM,DM,DM,DM,IF,DM…
- Timeout: bus_ready held 0, TIMEOUT_CYCLES=16 → dm_ready=1, dm_rdata=0, bus_err=1 on 16th BUSY cycle; IDLE next.
- Mid-transaction reset: rst=1 in BUSY_DM → next cycle all bus outputs 0, no dm_ready; a subsequent if_req is served normally.
- ARB_PERF_CNT_EN defined: 3 fetches and 2 data accesses with 4 overlap cycles → counters read 3/2/4.
